serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 140 ++++++++++++++
 tb/tb_serial_add_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester arbitrated adder that sums W = 4*N_NIB-bit operands one nibble per cycle.
// Latency: res_valid rises N_NIB cycles after the accept edge; one operation every N_NIB+2 cycles.
// Backpressure: the result holds in DONE until res_ready; no request is accepted outside IDLE.
// Ports: clk, rst (async, active-high); req0_*/req1_* valid/ready operand inputs (x, y);
//        res_valid/res_ready result handshake with res_s (sum), res_c (carry-out), res_id (owner).
module serial_add_arbiter #(
    parameter int N_NIB = 4,
    localparam int W = 4 * N_NIB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [W-1:0] res_s,
    output logic         res_c,
    output logic         res_id,
    input  logic         res_ready
);

    // Nibble counter width; a 1-nibble build still needs a 1-bit counter.
    localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  x_reg;
    logic [W-1:0]  y_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  sum_nxt;
    logic          id_reg;
    logic          carry;
    logic          prio;
    logic [KW-1:0] k;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          last_nib;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    add_res;

    // Single valid wins outright; when both are valid, prio picks the winner.
    assign grant0 = req0_valid & (~req1_valid | ~prio);
    assign grant1 = req1_valid & (~req0_valid |  prio);

    // rst gates ready so nothing can look accepted while reset is held.
    assign req0_ready = ~rst & (state == IDLE) & grant0;
    assign req1_ready = ~rst & (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

    assign res_valid  = (state == DONE);
    assign last_nib   = (k == KW'(N_NIB - 1));

    // The only adder in the design: one nibble plus the running carry.
    assign a_nib   = x_reg[4*k +: 4];
    assign b_nib   = y_reg[4*k +: 4];
    assign add_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    always_comb begin
        sum_nxt            = sum_reg;
        sum_nxt[4*k +: 4]  = add_res[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADD;
            ADD:     if (last_nib)  state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg   <= '0;
            y_reg   <= '0;
            sum_reg <= '0;
            id_reg  <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
            prio    <= 1'b0;
            res_s   <= '0;
            res_c   <= 1'b0;
            res_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg  <= req1_ready ? req1_x : req0_x;
                        y_reg  <= req1_ready ? req1_y : req0_y;
                        id_reg <= req1_ready;
                        k      <= '0;
                        carry  <= 1'b0;
                    end
                end
                ADD: begin
                    sum_reg <= sum_nxt;
                    carry   <= add_res[4];
                    k       <= k + 1'b1;
                    // Result registers change only on the edge that enters DONE.
                    if (last_nib) begin
                        res_s  <= sum_nxt;
                        res_c  <= add_res[4];
                        res_id <= id_reg;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        prio <= ~id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter (N_NIB = 4): reset, sums, carry chain,
// contention, fairness/throughput, result backpressure and reset during ADD.
// Inputs change 2 time units after a rising edge; outputs are checked there too.
module tb_serial_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic        req0_ready, req1_ready;
    logic        res_valid;
    logic [15:0] res_s;
    logic        res_c;
    logic        res_id;
    logic        res_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_add_arbiter #(.N_NIB(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_s      (res_s),
        .res_c      (res_c),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Counts edges until res_valid is seen (bounded); caller is just past the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!res_valid && lat < 30);
        chk("res_valid_seen", res_valid, 1);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] es, input logic ec, input logic eid);
        chk({tag, "_s"},  res_s,  es);
        chk({tag, "_c"},  res_c,  ec);
        chk({tag, "_id"}, res_id, eid);
    endtask

    // Offers one operand pair from a single requester, checks the accept and the result.
    task automatic run_op(input string tag, input logic who, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] es, input logic ec);
        int lat;
        if (who) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y;
        end
        #1;
        chk({tag, "_rdy0"}, req0_ready, !who);
        chk({tag, "_rdy1"}, req1_ready, who);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_rdy_add"}, {req0_ready, req1_ready}, 2'b00);
        wait_result(lat);
        chk({tag, "_lat"}, lat, 4);
        chk_res(tag, es, ec, who);
    endtask

    task automatic finish_op(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_released"}, res_valid, 0);
    endtask

    initial begin
        int lat;
        int prev_cyc;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        res_ready = 1'b0;

        // Reset state, with both requesters valid to prove ready is gated.
        step();
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk_res("rst", 16'h0000, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        step();

        // Basic and carry-chain sums.
        run_op("basic", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0);
        finish_op("basic");
        run_op("cc1", 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
        finish_op("cc1");
        run_op("cc2", 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        finish_op("cc2");
        run_op("cc3", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        finish_op("cc3");

        // Backpressure: result must hold for 3 stalled cycles while req0 waits.
        run_op("bp", 1'b1, 16'h8421, 16'hF111, 16'h7532, 1'b1);
        req0_valid = 1'b1; req0_x = 16'h1111; req0_y = 16'h2222;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_hold_valid", res_valid, 1);
            chk_res("bp_hold", 16'h7532, 1'b1, 1'b1);
            chk("bp_hold_rdy", {req0_ready, req1_ready}, 2'b00);
            step();
        end
        req0_valid = 1'b0;
        chk_res("bp_c4", 16'h7532, 1'b1, 1'b1);
        finish_op("bp");

        // Reset during ADD: accept a pair, process two nibbles, then reset.
        req0_valid = 1'b1; req0_x = 16'h1111; req0_y = 16'h2222;
        #1;
        chk("mid_accept_rdy", req0_ready, 1);
        step();
        step();
        step();
        chk("mid_add_valid", res_valid, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk_res("mid_rst", 16'h0000, 1'b0, 1'b0);
        chk("mid_rst_rdy", {req0_ready, req1_ready}, 2'b00);
        step();
        req0_valid = 1'b0;
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("mid_no_result", res_valid, 0);
        end
        chk("mid_res_s", res_s, 16'h0000);

        // Contention straight after reset: prio=0, so req0 first.
        req0_valid = 1'b1; req0_x = 16'hA000; req0_y = 16'h6000;
        req1_valid = 1'b1; req1_x = 16'h0003; req1_y = 16'h0004;
        #1;
        chk("cont_rdy", {req0_ready, req1_ready}, 2'b10);
        step();
        req0_valid = 1'b0;
        chk("cont_add_rdy", {req0_ready, req1_ready}, 2'b00);
        wait_result(lat);
        chk("cont_lat0", lat, 4);
        chk_res("cont0", 16'h0000, 1'b1, 1'b0);
        chk("cont_done_rdy", {req0_ready, req1_ready}, 2'b00);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("cont_idle_valid", res_valid, 0);
        chk("cont_idle_rdy", {req0_ready, req1_ready}, 2'b01);
        step();
        req1_valid = 1'b0;
        wait_result(lat);
        chk("cont_lat1", lat, 4);
        chk_res("cont1", 16'h0007, 1'b0, 1'b1);
        finish_op("cont1");

        // Fairness and throughput: both valid throughout, res_ready held high.
        req0_valid = 1'b1; req0_x = 16'h0100; req0_y = 16'h0020;
        req1_valid = 1'b1; req1_x = 16'h1000; req1_y = 16'h0003;
        res_ready  = 1'b1;
        #1;
        chk("fair_first_rdy", {req0_ready, req1_ready}, 2'b10);
        prev_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            wait_result(lat);
            chk("fair_id", res_id, i % 2);
            chk("fair_s", res_s, (i % 2) ? 16'h1003 : 16'h0120);
            if (i > 0) chk("fair_period", cyc - prev_cyc, 6);
            prev_cyc = cyc;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        res_ready = 1'b0;
        chk("fair_end_valid", res_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
